// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter: source indices,
// RegDst select codes and the fixed $29/$31 destinations.
// Pure declarations, no logic; imported by regfile_wr_arbiter and rr_pick4.
package regwr_pkg;

  // Request/ack bit position of each write source
  localparam int SRC_RT = 0;
  localparam int SRC_RD = 1;
  localparam int SRC_SP = 2;
  localparam int SRC_RA = 3;

  // RegDst mux select code; numerically equal to the source index
  typedef logic [1:0] regdst_t;

  localparam regdst_t RDST_RT = 2'b00;
  localparam regdst_t RDST_RD = 2'b01;
  localparam regdst_t RDST_SP = 2'b10;
  localparam regdst_t RDST_RA = 2'b11;

  // Implicit destinations for stack-pointer and link writes
  localparam logic [4:0] REG_SP = 5'd29;
  localparam logic [4:0] REG_RA = 5'd31;

  // One-hot request/ack mask for a select code
  function automatic logic [3:0] sel_onehot(input regdst_t sel);
    logic [3:0] oh;
    oh = 4'b0000;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick4.sv
// rr_pick4: 4-way round-robin picker; search starts at index ptr and wraps.
// Latency: purely combinational. Backpressure: none, a grant is only a selection.
// Only built when REGWR_RR_EN is defined; the fixed-priority build never uses it.
`ifdef REGWR_RR_EN
module rr_pick4
  import regwr_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic       vld
);

  // Walk ptr, ptr+1, ... (mod 4) and grant the first requesting index
  always_comb begin
    logic [1:0] idx;
    gnt = 4'b0000;
    idx = 2'b00;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + k[1:0];
      if ((gnt == 4'b0000) && req[idx]) begin
        gnt[idx] = 1'b1;
      end
    end
    vld = |req;
  end

endmodule
`endif

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: grants one of four register-file write sources per cycle (macro REGWR_RR_EN = round-robin, else fixed ra>sp>rd>rt).
// Latency: req before edge N -> registered reg_write/ack/wr_* valid for cycle N..N+1.
// Backpressure: losers hold req; the source acked this cycle is masked so it is never granted twice in a row.
module regfile_wr_arbiter
  import regwr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        req,
  input  logic [4:0]        rt_addr,
  input  logic [4:0]        rd_addr,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  input  logic [DATA_W-1:0] wdata3,
  output logic [3:0]        ack,
  output logic [1:0]        regdst_sel,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              reg_write,
  output logic              busy
);

  logic [3:0]        ack_q, ack_d;
  logic              reg_write_q, reg_write_d;
  regdst_t           regdst_sel_q, regdst_sel_d;
  logic [4:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic [3:0] elig;
  logic       grant_vld;
  regdst_t    grant_idx;

  // A requester sees its ack one cycle before it can drop req, so mask it here
  assign elig = req & ~ack_q;

`ifdef REGWR_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] rr_gnt;

  rr_pick4 u_rr_pick4 (
    .req (elig),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .vld (grant_vld)
  );

  // Encode the one-hot round-robin grant into a select code
  always_comb begin
    grant_idx = RDST_RT;
    unique case (rr_gnt)
      4'b0010: grant_idx = RDST_RD;
      4'b0100: grant_idx = RDST_SP;
      4'b1000: grant_idx = RDST_RA;
      default: grant_idx = RDST_RT;
    endcase
  end

  // Next search starts just past the winner; pointer holds when nothing is granted
  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = grant_idx + 2'd1;
    end
  end

  // Round-robin pointer; reset points at rt so rt wins first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 2'b00;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority ra > sp > rd > rt
  always_comb begin
    grant_vld = |elig;
    grant_idx = RDST_RT;
    if (elig[SRC_RA]) begin
      grant_idx = RDST_RA;
    end else if (elig[SRC_SP]) begin
      grant_idx = RDST_SP;
    end else if (elig[SRC_RD]) begin
      grant_idx = RDST_RD;
    end
  end
`endif

  // Resolve the winner's destination/data; $0 retires the requester without writing
  always_comb begin
    ack_d        = 4'b0000;
    reg_write_d  = 1'b0;
    regdst_sel_d = regdst_sel_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (grant_vld) begin
      regdst_sel_d = grant_idx;
      unique case (grant_idx)
        RDST_RT: begin wr_addr_d = rt_addr; wr_data_d = wdata0; end
        RDST_RD: begin wr_addr_d = rd_addr; wr_data_d = wdata1; end
        RDST_SP: begin wr_addr_d = REG_SP;  wr_data_d = wdata2; end
        default: begin wr_addr_d = REG_RA;  wr_data_d = wdata3; end
      endcase
      ack_d       = sel_onehot(grant_idx);
      reg_write_d = (wr_addr_d != 5'd0);
    end
  end

  // Write-stage register: WRITE when ack/reg_write are set, IDLE otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q        <= 4'b0000;
      reg_write_q  <= 1'b0;
      regdst_sel_q <= RDST_RT;
      wr_addr_q    <= 5'd0;
      wr_data_q    <= '0;
    end else begin
      ack_q        <= ack_d;
      reg_write_q  <= reg_write_d;
      regdst_sel_q <= regdst_sel_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign ack        = ack_q;
  assign reg_write  = reg_write_q;
  assign regdst_sel = regdst_sel_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = |req;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: expected writes are queued when stimulus
// is driven and popped when an ack appears; compares via immediate assertions.
// Requesters drop req on seeing their ack unless auto_drop is cleared.
module tb_regfile_wr_arbiter;

  typedef struct {
    logic [3:0]  ack;
    logic [1:0]  sel;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        we;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [4:0]  rt_addr, rd_addr;
  logic [31:0] wdata0, wdata1, wdata2, wdata3;
  logic [3:0]  ack;
  logic [1:0]  regdst_sel;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        reg_write;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit auto_drop = 1'b1;
  wr_exp_t sb[$];

  regfile_wr_arbiter #(.DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .rt_addr    (rt_addr),
    .rd_addr    (rd_addr),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .wdata2     (wdata2),
    .wdata3     (wdata3),
    .ack        (ack),
    .regdst_sel (regdst_sel),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .reg_write  (reg_write),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [1:0] s, input logic [4:0] ad,
                      input logic [31:0] d, input logic w);
    wr_exp_t e;
    e.ack = a; e.sel = s; e.addr = ad; e.data = d; e.we = w;
    sb.push_back(e);
  endtask

  // Advance to the next falling edge and check for a write (exp_wr) or an idle cycle
  task automatic step(input bit exp_wr);
    wr_exp_t e;
    @(negedge clk);
    if (exp_wr) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("ack", 64'(ack), 64'(e.ack));
        chk("regdst_sel", 64'(regdst_sel), 64'(e.sel));
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", 64'(wr_data), 64'(e.data));
        chk("reg_write", 64'(reg_write), 64'(e.we));
      end
    end else begin
      chk("idle_ack", 64'(ack), 64'd0);
      chk("idle_reg_write", 64'(reg_write), 64'd0);
    end
    if (auto_drop) req = req & ~ack;
  endtask

  initial begin
    reset   = 1'b1;
    req     = 4'b1111;
    rt_addr = 5'd5;
    rd_addr = 5'd12;
    wdata0  = 32'h1111_0000;
    wdata1  = 32'h2222_0001;
    wdata2  = 32'h3333_0002;
    wdata3  = 32'h4444_0003;

    // Reset held with every source requesting
    repeat (2) @(negedge clk);
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_regdst_sel", 64'(regdst_sel), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);

    // All four held until acked: four back-to-back writes
`ifdef REGWR_RR_EN
    push(4'b0001, 2'b00, 5'd5,  32'h1111_0000, 1'b1);
    push(4'b0010, 2'b01, 5'd12, 32'h2222_0001, 1'b1);
    push(4'b0100, 2'b10, 5'd29, 32'h3333_0002, 1'b1);
    push(4'b1000, 2'b11, 5'd31, 32'h4444_0003, 1'b1);
`else
    push(4'b1000, 2'b11, 5'd31, 32'h4444_0003, 1'b1);
    push(4'b0100, 2'b10, 5'd29, 32'h3333_0002, 1'b1);
    push(4'b0010, 2'b01, 5'd12, 32'h2222_0001, 1'b1);
    push(4'b0001, 2'b00, 5'd5,  32'h1111_0000, 1'b1);
`endif
    reset = 1'b0;
    repeat (4) step(1'b1);
    chk("busy_after_last_ack", 64'(busy), 64'd0);
    step(1'b0);

    // Single rt write; later wdata change must not disturb held outputs
    rt_addr = 5'd8;
    wdata0  = 32'hDEAD_BEEF;
    req     = 4'b0001;
    push(4'b0001, 2'b00, 5'd8, 32'hDEAD_BEEF, 1'b1);
    step(1'b1);
    wdata0  = 32'h0BAD_F00D;
    rt_addr = 5'd9;
    step(1'b0);
    step(1'b0);
    chk("hold_wr_data", 64'(wr_data), 64'hDEAD_BEEF);
    chk("hold_wr_addr", 64'(wr_addr), 64'd8);
    chk("hold_regdst_sel", 64'(regdst_sel), 64'd0);

    // sp req left high after ack: masked one cycle, then written again
    auto_drop = 1'b0;
    wdata2 = 32'h5A5A_5A5A;
    req    = 4'b0100;
    push(4'b0100, 2'b10, 5'd29, 32'h5A5A_5A5A, 1'b1);
    push(4'b0100, 2'b10, 5'd29, 32'h5A5A_5A5A, 1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    req = 4'b0000;
    auto_drop = 1'b1;
    step(1'b0);

    // rd targeting $0: ack pulses but no register write
    rd_addr = 5'd0;
    wdata1  = 32'hCAFE_0000;
    req     = 4'b0010;
    push(4'b0010, 2'b01, 5'd0, 32'hCAFE_0000, 1'b0);
    step(1'b1);
    step(1'b0);

    // rt and rd requested together: both served on consecutive edges
    rd_addr = 5'd17;
    rt_addr = 5'd3;
    wdata0  = 32'h0000_0AAA;
    wdata1  = 32'h0000_0BBB;
    req     = 4'b0011;
`ifdef REGWR_RR_EN
    push(4'b0001, 2'b00, 5'd3,  32'h0000_0AAA, 1'b1);
    push(4'b0010, 2'b01, 5'd17, 32'h0000_0BBB, 1'b1);
`else
    push(4'b0010, 2'b01, 5'd17, 32'h0000_0BBB, 1'b1);
    push(4'b0001, 2'b00, 5'd3,  32'h0000_0AAA, 1'b1);
`endif
    step(1'b1);
    step(1'b1);
    step(1'b0);

    // Reset during an active write clears outputs without a clock edge
    rt_addr = 5'd20;
    wdata0  = 32'h7777_7777;
    req     = 4'b0001;
    push(4'b0001, 2'b00, 5'd20, 32'h7777_7777, 1'b1);
    step(1'b1);
    req   = 4'b0000;
    reset = 1'b1;
    #1;
    chk("async_rst_reg_write", 64'(reg_write), 64'd0);
    chk("async_rst_ack", 64'(ack), 64'd0);
    chk("async_rst_wr_addr", 64'(wr_addr), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Register-file write-port arbiter for the multicycle MIPS datapath. Four write sources compete for the single register-file write port: load/immediate to rt, R-type result to rd, stack-pointer update to $29, and link address to $31. The block grants one source per cycle, drives the RegDst mux select code, write data and RegWrite from a registered write stage, and acknowledges the winning requester. Multi-write instructions such as pop/`jal` variants rely on it to serialize their writes without extra control-unit states.

## Interface
- `DATA_W`, default 32: register data width.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `req`  in  4: request per source; bit0 rt, bit1 rd, bit2 sp($29), bit3 ra($31). Held high until `ack`.
- `rt_addr`  in  5: instruction[20:16].
- `rd_addr`  in  5: instruction[15:11].
- `wdata0..wdata3`  in  DATA_W each: write data per source, stable while its `req` is high.
- `ack`  out  4: one-hot, one-cycle pulse, asserted in the write cycle of that source.
- `regdst_sel`  out  2: RegDst code, 00 rt, 01 rd, 10 $29, 11 $31.
- `wr_addr`  out  5: resolved destination register.
- `wr_data`  out  DATA_W: write data.
- `reg_write`  out  1: register-file write enable.
- `busy`  out  1: high when any `req` bit is unserved, including the granted one.

## Operation
- Two-stage behaviour: arbitration is combinational on registered state; the write stage is registered.
- Eligible set = `req` & ~`ack`. The source acked in the current cycle is masked so it is never granted twice.
- Winner selection:
  - Fixed priority ra > sp > rd > rt without the configuration macro.
  - Round-robin with the macro defined (see Configuration).
- On a clock edge with a non-empty eligible set, the winner's index loads `regdst_sel`. `wr_addr` loads rt_addr, rd_addr, 29 or 31. `wr_data` loads the winner's wdata. `reg_write` and `ack[winner]` are set.
- With an empty eligible set, `reg_write` and `ack` load 0. `regdst_sel`, `wr_addr` and `wr_data` hold their previous values.
- Register $0 guard: if the resolved `wr_addr` is 0, `reg_write` stays 0 but `ack` still pulses, so the requester retires.
- No state machine beyond the write-stage register and the round-robin pointer. The write stage is either WRITE (`reg_write`/`ack` valid) or IDLE.
- Reset state, asynchronous:
  - `ack`=0, `reg_write`=0, `regdst_sel`=00, `wr_addr`=0, `wr_data`=0.
  - Round-robin pointer = rt (bit0).
- `busy` is combinational: |`req`.
- Reset asserted mid-write clears `reg_write`/`ack` immediately. An in-flight write that has not reached its clock edge is lost, and the requester must re-request after reset.

## Timing
- Latency: `req` rising before edge N gives `reg_write`/`ack` high during cycle N to N+1. The register file commits at edge N+1.
- Throughput: one write per cycle. With all four `req` held high, four consecutive write cycles occur.
- A requester drops `req` in the cycle after `ack`. If `req` is still high one cycle after `ack`, a second write is issued.
- Simultaneous requests resolve in the same edge. Losers keep `req` high and are unaffected.
- Addresses and data are sampled at the grant edge only. Later changes do not affect the in-flight write.

## Configuration
- `REGWR_RR_EN` defined:
  - Round-robin arbitration. The search starts at the source after the last granted one.
  - The pointer advances only on a grant.
- `REGWR_RR_EN` undefined:
  - Fixed priority ra > sp > rd > rt.
  - The pointer register is not built.

## Structure
- Package `regwr_pkg`:
  - Source index constants SRC_RT=0, SRC_RD=1, SRC_SP=2, SRC_RA=3.
  - RegDst codes.
  - Fixed addresses REG_SP=5'd29 and REG_RA=5'd31.
  - Typedef for the 2-bit select.
- Sub-module `rr_pick4`: combinational 4-way picker with pointer input, one-hot grant out and valid out. It is instantiated only under `REGWR_RR_EN`.

## Test plan
1. Reset held, all `req`=1 → `reg_write`=0, `ack`=0, `wr_addr`=0. Release reset → first write is $31 (fixed) or rt (RR).
2. `req`=0001, rt_addr=8, wdata0=0xDEADBEEF → next cycle `regdst_sel`=00, `wr_addr`=8, `wr_data`=0xDEADBEEF, `ack`=0001. Drop `req` → no further write.
3. `req`=1111 held until each ack, fixed priority → write order $31, $29, rd, rt in four consecutive cycles. `busy` falls after the last ack.
4. `REGWR_RR_EN`, `req`=0011 held continuously → grants alternate rd, rt, rd, rt.
5. `req`=0010, rd_addr=0 → `ack`=0010 and `reg_write`=0.
6. Reset asserted while `reg_write`=1 → `reg_write` and `ack` go 0 without waiting for a clock edge.
